// File: rtl/fdc_xfer_if.sv
// Floppy transfer engine bus: command, CPU byte port, disk port, status.
// master = host/disk side, slave = fdc_xfer_engine.
interface fdc_xfer_if #(
  parameter int NUM_DRIVES = 2
);
  localparam int DRV_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;

  logic             start;
  logic             dir;
  logic [DRV_W-1:0] drive;
  logic [2:0]       n_code;
  logic [7:0]       first_sec;
  logic [7:0]       eot;
  logic [7:0]       cyl;
  logic             head;
  logic             cpu_rd;
  logic             cpu_wr;
  logic [7:0]       cpu_din;
  logic [7:0]       cpu_dout;
  logic             tc;
  logic             rqm;
  logic             req_rd;
  logic             req_wr;
  logic [DRV_W-1:0] req_drive;
  logic [16:0]      req_chs;
  logic             disk_done;
  logic             disk_err;
  logic             disk_wr_en;
  logic [7:0]       disk_din;
  logic             disk_rd_en;
  logic [7:0]       disk_dout;
  logic             busy;
  logic             done;
  logic             st_err;
  logic             st_ovr;
  logic             st_eoc;
  logic [7:0]       last_sec;

  modport master (
    output start, dir, drive, n_code, first_sec, eot, cyl, head,
    output cpu_rd, cpu_wr, cpu_din, tc,
    output disk_done, disk_err, disk_wr_en, disk_din, disk_rd_en,
    input  cpu_dout, rqm, req_rd, req_wr, req_drive, req_chs,
    input  disk_dout, busy, done, st_err, st_ovr, st_eoc, last_sec
  );

  modport slave (
    input  start, dir, drive, n_code, first_sec, eot, cyl, head,
    input  cpu_rd, cpu_wr, cpu_din, tc,
    input  disk_done, disk_err, disk_wr_en, disk_din, disk_rd_en,
    output cpu_dout, rqm, req_rd, req_wr, req_drive, req_chs,
    output disk_dout, busy, done, st_err, st_ovr, st_eoc, last_sec
  );
endinterface

// File: rtl/fdc_xfer_engine.sv
// Floppy sector transfer engine: buffers one sector between disk and CPU.
// Ports: clk, rst_n (async, active low), bus (fdc_xfer_if.slave).
module fdc_xfer_engine #(
  parameter int NUM_DRIVES  = 2,
  parameter int MAX_N       = 2,
  parameter int OVR_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  fdc_xfer_if.slave   bus
);
  localparam int DRV_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
  localparam int DEPTH = 128 << MAX_N;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int OW    = $clog2(OVR_TIMEOUT + 1);
  localparam logic [2:0] MAXN3 = 3'(MAX_N);
  localparam logic [OW-1:0] OVR_LAST = OW'(OVR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, XFER_OUT, XFER_IN, WR_REQ, FINISH
  } state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [DRV_W-1:0] drive_q, drive_d;
  logic [LW-1:0]    len_q, len_d;
  logic [7:0]       sec_q, sec_d;
  logic [7:0]       eot_q, eot_d;
  logic [7:0]       cyl_q, cyl_d;
  logic             head_q, head_d;
  logic             tc_q, tc_d;
  logic [LW-1:0]    fptr_q, fptr_d;
  logic [LW-1:0]    cptr_q, cptr_d;
  logic [LW-1:0]    dptr_q, dptr_d;
  logic [OW-1:0]    ovr_q, ovr_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             eoc_q, eoc_d;
  logic [7:0]       last_q, last_d;

  logic [7:0]    mem_q [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  logic          sec_end;
  state_e        nxt_st;
  logic          tc_eff;
  logic [2:0]    n_eff;
  logic          strobe;

  // tc arriving with the final byte still counts for this sector
  assign tc_eff = tc_q | bus.tc;
  assign n_eff  = (bus.n_code > MAXN3) ? MAXN3 : bus.n_code;
  assign strobe = bus.cpu_rd | bus.cpu_wr;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    drive_d = drive_q;
    len_d   = len_q;
    sec_d   = sec_q;
    eot_d   = eot_q;
    cyl_d   = cyl_q;
    head_d  = head_q;
    tc_d    = tc_q;
    fptr_d  = fptr_q;
    cptr_d  = cptr_q;
    dptr_d  = dptr_q;
    ovr_d   = '0;
    err_d   = err_q;
    ovf_d   = ovf_q;
    eoc_d   = eoc_q;
    last_d  = last_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    sec_end = 1'b0;
    nxt_st  = IDLE;

    if (state_q != IDLE && bus.tc) tc_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dir_d   = bus.dir;
          drive_d = bus.drive;
          len_d   = LW'(32'd128 << n_eff);
          sec_d   = bus.first_sec;
          eot_d   = bus.eot;
          cyl_d   = bus.cyl;
          head_d  = bus.head;
          tc_d    = 1'b0;
          fptr_d  = '0;
          cptr_d  = '0;
          dptr_d  = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          eoc_d   = 1'b0;
          last_d  = '0;
          state_d = bus.dir ? RD_REQ : XFER_IN;
        end
      end
      RD_REQ: begin
        if (bus.disk_wr_en && fptr_q < len_q) begin
          we     = 1'b1;
          waddr  = fptr_q[AW-1:0];
          wdata  = bus.disk_din;
          fptr_d = fptr_q + LW'(1);
        end
        if (bus.disk_done) begin
          if (bus.disk_err) begin
            err_d   = 1'b1;
            last_d  = sec_q;
            state_d = FINISH;
          end else begin
            state_d = XFER_OUT;
          end
        end
      end
      XFER_OUT: begin
        if (bus.cpu_rd) begin
          cptr_d = cptr_q + LW'(1);
          if (cptr_d == len_q) begin
            sec_end = 1'b1;
            nxt_st  = RD_REQ;
          end
        end else if (!strobe) begin
          ovr_d = ovr_q + OW'(1);
        end
      end
      XFER_IN: begin
        if (bus.cpu_wr) begin
          we     = 1'b1;
          waddr  = cptr_q[AW-1:0];
          wdata  = bus.cpu_din;
          cptr_d = cptr_q + LW'(1);
          if (cptr_d == len_q) state_d = WR_REQ;
        end else if (!strobe) begin
          ovr_d = ovr_q + OW'(1);
        end
      end
      WR_REQ: begin
        if (bus.disk_rd_en && dptr_q < len_q - LW'(1))
          dptr_d = dptr_q + LW'(1);
        if (bus.disk_done) begin
          if (bus.disk_err) begin
            err_d   = 1'b1;
            last_d  = sec_q;
            state_d = FINISH;
          end else begin
            sec_end = 1'b1;
            nxt_st  = XFER_IN;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // idle CPU too long while a byte is pending
    if ((state_q == XFER_OUT || state_q == XFER_IN) && !strobe
        && ovr_q == OVR_LAST) begin
      ovf_d   = 1'b1;
      last_d  = sec_q;
      state_d = FINISH;
    end

    if (sec_end) begin
      if (tc_eff || sec_q == eot_q) begin
        eoc_d   = (sec_q == eot_q) && !tc_eff;
        last_d  = sec_q;
        state_d = FINISH;
      end else begin
        sec_d   = sec_q + 8'd1;
        fptr_d  = '0;
        cptr_d  = '0;
        dptr_d  = '0;
        state_d = nxt_st;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      drive_q <= '0;
      len_q   <= '0;
      sec_q   <= '0;
      eot_q   <= '0;
      cyl_q   <= '0;
      head_q  <= 1'b0;
      tc_q    <= 1'b0;
      fptr_q  <= '0;
      cptr_q  <= '0;
      dptr_q  <= '0;
      ovr_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      eoc_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      drive_q <= drive_d;
      len_q   <= len_d;
      sec_q   <= sec_d;
      eot_q   <= eot_d;
      cyl_q   <= cyl_d;
      head_q  <= head_d;
      tc_q    <= tc_d;
      fptr_q  <= fptr_d;
      cptr_q  <= cptr_d;
      dptr_q  <= dptr_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      eoc_q   <= eoc_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FINISH);
  assign bus.rqm       = (state_q == XFER_OUT) || (state_q == XFER_IN);
  assign bus.req_rd    = (state_q == RD_REQ);
  assign bus.req_wr    = (state_q == WR_REQ);
  assign bus.req_drive = drive_q;
  assign bus.req_chs   = {head_q, cyl_q, sec_q};
  assign bus.cpu_dout  = (state_q == XFER_OUT) ? mem_q[cptr_q[AW-1:0]] : 8'h00;
  assign bus.disk_dout = (state_q == WR_REQ) ? mem_q[dptr_q[AW-1:0]] : 8'h00;
  assign bus.st_err    = err_q;
  assign bus.st_ovr    = ovf_q;
  assign bus.st_eoc    = eoc_q;
  assign bus.last_sec  = last_q;
endmodule

// File: tb/tb_fdc_xfer_engine.sv
// Directed bench for fdc_xfer_engine: read, tc, write error, overrun,
// sector wrap and reset abort scenarios.
module tb_fdc_xfer_engine;
  localparam int T = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  fdc_xfer_if #(.NUM_DRIVES(2)) bus ();

  fdc_xfer_engine #(
    .NUM_DRIVES(2), .MAX_N(2), .OVR_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dbyte(input logic [7:0] s, input int i);
    return 8'(i * 13 + (i >> 8)) ^ s;
  endfunction

  function automatic logic [7:0] wbyte(input int i);
    return 8'(255 - i * 3);
  endfunction

  task automatic start_cmd(input logic d, input logic [2:0] n,
                           input logic [7:0] fs, input logic [7:0] e);
    bus.start = 1'b1;
    bus.dir = d;
    bus.n_code = n;
    bus.first_sec = fs;
    bus.eot = e;
    bus.cyl = 8'h12;
    bus.head = 1'b1;
    bus.drive = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic disk_feed(input logic [7:0] s, input int len,
                           input logic err);
    for (int i = 0; i < len; i++) begin
      bus.disk_wr_en = 1'b1;
      bus.disk_din = dbyte(s, i);
      @(negedge clk);
    end
    bus.disk_wr_en = 1'b0;
    bus.disk_done = 1'b1;
    bus.disk_err = err;
    @(negedge clk);
    bus.disk_done = 1'b0;
    bus.disk_err = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] s, input int from, input int len,
                          input int tc_at, output int bad);
    bad = 0;
    for (int i = from; i < len; i++) begin
      if (bus.cpu_dout !== dbyte(s, i)) bad++;
      bus.cpu_rd = 1'b1;
      bus.tc = (i == tc_at);
      @(negedge clk);
    end
    bus.cpu_rd = 1'b0;
    bus.tc = 1'b0;
  endtask

  task automatic test_reset;
    vectors++;
    if ({bus.busy, bus.done, bus.rqm, bus.req_rd, bus.req_wr,
         bus.req_drive, bus.req_chs, bus.cpu_dout, bus.disk_dout,
         bus.st_err, bus.st_ovr, bus.st_eoc, bus.last_sec} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b rqm=%b chs=%h last=%h need all 0",
               bus.busy, bus.rqm, bus.req_chs, bus.last_sec);
    end
  endtask

  task automatic test_read_eoc;
    int bad;
    start_cmd(1'b1, 3'd2, 8'hC1, 8'hC2);
    vectors++;
    if ({bus.busy, bus.req_rd, bus.req_drive, bus.req_chs} !==
        {1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'hC1}) begin
      miscompares++;
      $display("FAIL rd_req1: got busy=%b req_rd=%b drv=%b chs=%h need 1 1 1 1_12_c1",
               bus.busy, bus.req_rd, bus.req_drive, bus.req_chs);
    end
    disk_feed(8'hC1, 512, 1'b0);
    cpu_read(8'hC1, 0, 512, -1, bad);
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL rd_data_c1: got %0d bad bytes need 0", bad);
    end
    vectors++;
    if ({bus.req_rd, bus.req_chs[7:0]} !== {1'b1, 8'hC2}) begin
      miscompares++;
      $display("FAIL rd_req2: got req_rd=%b sec=%h need 1 c2",
               bus.req_rd, bus.req_chs[7:0]);
    end
    disk_feed(8'hC2, 512, 1'b0);
    cpu_read(8'hC2, 0, 512, -1, bad);
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL rd_data_c2: got %0d bad bytes need 0", bad);
    end
    vectors++;
    if ({bus.done, bus.busy, bus.st_eoc, bus.st_err, bus.st_ovr, bus.last_sec}
        !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC2}) begin
      miscompares++;
      $display("FAIL rd_done: got done=%b busy=%b eoc=%b err=%b ovr=%b last=%h need 1 1 1 0 0 c2",
               bus.done, bus.busy, bus.st_eoc, bus.st_err, bus.st_ovr, bus.last_sec);
    end
    @(negedge clk);
    vectors++;
    if ({bus.done, bus.busy, bus.st_eoc, bus.last_sec} !==
        {1'b0, 1'b0, 1'b1, 8'hC2}) begin
      miscompares++;
      $display("FAIL rd_hold: got done=%b busy=%b eoc=%b last=%h need 0 0 1 c2",
               bus.done, bus.busy, bus.st_eoc, bus.last_sec);
    end
  endtask

  task automatic test_read_tc;
    int bad;
    start_cmd(1'b1, 3'd2, 8'hC1, 8'hC9);
    bus.start = 1'b1;
    bus.dir = 1'b0;
    bus.first_sec = 8'h33;
    @(negedge clk);
    bus.start = 1'b0;
    vectors++;
    if ({bus.req_rd, bus.req_chs[7:0]} !== {1'b1, 8'hC1}) begin
      miscompares++;
      $display("FAIL start_ignored: got req_rd=%b sec=%h need 1 c1",
               bus.req_rd, bus.req_chs[7:0]);
    end
    disk_feed(8'hC1, 512, 1'b0);
    cpu_read(8'hC1, 0, 512, 100, bad);
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL tc_data: got %0d bad bytes need 0", bad);
    end
    vectors++;
    if ({bus.done, bus.req_rd, bus.st_eoc, bus.last_sec} !==
        {1'b1, 1'b0, 1'b0, 8'hC1}) begin
      miscompares++;
      $display("FAIL tc_done: got done=%b req_rd=%b eoc=%b last=%h need 1 0 0 c1",
               bus.done, bus.req_rd, bus.st_eoc, bus.last_sec);
    end
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.req_rd} !== 2'b00) begin
      miscompares++;
      $display("FAIL tc_idle: got busy=%b req_rd=%b need 0 0",
               bus.busy, bus.req_rd);
    end
  endtask

  task automatic test_write_err;
    int bad;
    start_cmd(1'b0, 3'd0, 8'h10, 8'h10);
    vectors++;
    if ({bus.rqm, bus.req_wr, bus.busy} !== 3'b101) begin
      miscompares++;
      $display("FAIL wr_xfer_in: got rqm=%b req_wr=%b busy=%b need 1 0 1",
               bus.rqm, bus.req_wr, bus.busy);
    end
    for (int i = 0; i < 128; i++) begin
      bus.cpu_wr = 1'b1;
      bus.cpu_din = wbyte(i);
      @(negedge clk);
    end
    bus.cpu_wr = 1'b0;
    vectors++;
    if ({bus.rqm, bus.req_wr, bus.req_chs[7:0]} !== {1'b0, 1'b1, 8'h10}) begin
      miscompares++;
      $display("FAIL wr_req: got rqm=%b req_wr=%b sec=%h need 0 1 10",
               bus.rqm, bus.req_wr, bus.req_chs[7:0]);
    end
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (bus.disk_dout !== wbyte(i)) bad++;
      bus.disk_rd_en = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (bus.disk_dout !== wbyte(127)) begin
      miscompares++;
      $display("FAIL wr_saturate: got %h need %h", bus.disk_dout, wbyte(127));
    end
    bus.disk_rd_en = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL wr_data: got %0d bad bytes need 0", bad);
    end
    bus.disk_done = 1'b1;
    bus.disk_err = 1'b1;
    @(negedge clk);
    bus.disk_done = 1'b0;
    bus.disk_err = 1'b0;
    vectors++;
    if ({bus.done, bus.st_err, bus.st_eoc, bus.last_sec} !==
        {1'b1, 1'b1, 1'b0, 8'h10}) begin
      miscompares++;
      $display("FAIL wr_err: got done=%b err=%b eoc=%b last=%h need 1 1 0 10",
               bus.done, bus.st_err, bus.st_eoc, bus.last_sec);
    end
    @(negedge clk);
  endtask

  task automatic test_overrun;
    int bad;
    start_cmd(1'b1, 3'd0, 8'h05, 8'h05);
    disk_feed(8'h05, 128, 1'b0);
    repeat (T - 1) @(negedge clk);
    vectors++;
    if ({bus.rqm, bus.done} !== 2'b10) begin
      miscompares++;
      $display("FAIL ovr_early: got rqm=%b done=%b need 1 0", bus.rqm, bus.done);
    end
    @(negedge clk);
    vectors++;
    if ({bus.done, bus.st_ovr, bus.st_err, bus.last_sec} !==
        {1'b1, 1'b1, 1'b0, 8'h05}) begin
      miscompares++;
      $display("FAIL ovr_hit: got done=%b ovr=%b err=%b last=%h need 1 1 0 05",
               bus.done, bus.st_ovr, bus.st_err, bus.last_sec);
    end
    @(negedge clk);
    start_cmd(1'b1, 3'd0, 8'h05, 8'h05);
    disk_feed(8'h05, 128, 1'b0);
    repeat (T - 1) @(negedge clk);
    bus.cpu_rd = 1'b1;
    @(negedge clk);
    bus.cpu_rd = 1'b0;
    vectors++;
    if ({bus.busy, bus.rqm, bus.st_ovr} !== 3'b110) begin
      miscompares++;
      $display("FAIL ovr_saved: got busy=%b rqm=%b ovr=%b need 1 1 0",
               bus.busy, bus.rqm, bus.st_ovr);
    end
    cpu_read(8'h05, 1, 128, -1, bad);
    vectors++;
    if ({bus.done, bus.st_ovr, bus.st_eoc, bad == 0} !== 4'b1011) begin
      miscompares++;
      $display("FAIL ovr_finish: got done=%b ovr=%b eoc=%b bad=%0d need 1 0 1 0",
               bus.done, bus.st_ovr, bus.st_eoc, bad);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int bad;
    start_cmd(1'b1, 3'd5, 8'hFF, 8'h00);
    vectors++;
    if (bus.req_chs[7:0] !== 8'hFF) begin
      miscompares++;
      $display("FAIL wrap_first: got %h need ff", bus.req_chs[7:0]);
    end
    disk_feed(8'hFF, 512, 1'b0);
    cpu_read(8'hFF, 0, 512, -1, bad);
    vectors++;
    if ({bus.req_rd, bus.req_chs[7:0], bad == 0} !== {1'b1, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_next: got req_rd=%b sec=%h bad=%0d need 1 00 0",
               bus.req_rd, bus.req_chs[7:0], bad);
    end
    disk_feed(8'h00, 512, 1'b0);
    cpu_read(8'h00, 0, 512, -1, bad);
    vectors++;
    if ({bus.done, bus.st_eoc, bus.last_sec, bad == 0} !==
        {1'b1, 1'b1, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_done: got done=%b eoc=%b last=%h bad=%0d need 1 1 00 0",
               bus.done, bus.st_eoc, bus.last_sec, bad);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    logic saw_done;
    start_cmd(1'b0, 3'd0, 8'h20, 8'h20);
    for (int i = 0; i < 10; i++) begin
      bus.cpu_wr = 1'b1;
      bus.cpu_din = wbyte(i);
      @(negedge clk);
    end
    bus.cpu_wr = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.rqm, bus.done} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_async: got busy=%b rqm=%b done=%b need 0 0 0",
               bus.busy, bus.rqm, bus.done);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done |= bus.done;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      saw_done |= bus.done;
    end
    vectors++;
    if ({saw_done, bus.busy, bus.req_chs, bus.last_sec} !== '0) begin
      miscompares++;
      $display("FAIL abort_quiet: got done_seen=%b busy=%b chs=%h last=%h need 0 0 0 0",
               saw_done, bus.busy, bus.req_chs, bus.last_sec);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dir = 1'b0;
    bus.drive = '0;
    bus.n_code = '0;
    bus.first_sec = '0;
    bus.eot = '0;
    bus.cyl = '0;
    bus.head = 1'b0;
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.cpu_din = '0;
    bus.tc = 1'b0;
    bus.disk_done = 1'b0;
    bus.disk_err = 1'b0;
    bus.disk_wr_en = 1'b0;
    bus.disk_din = '0;
    bus.disk_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_read_eoc();
    test_read_tc();
    test_write_err();
    test_overrun();
    test_wrap();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
